// File: rtl/fsm_stim_driver.sv
// fsm_stim_driver: initiator-side sequencer for the start/d/done handshake.
// The host loads up to DEPTH words. On go the block pulses start for one cycle
// and streams the words onto d, then holds the last word until done arrives or
// the timeout expires. It then reports pass/fail and the measured latency.
module fsm_stim_driver #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  input  logic                     clr,
  input  logic                     go,
  output logic                     start,
  output logic [15:0]              d,
  input  logic                     done,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic [CW-1:0]            latency,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int DATA_W = 16;
  localparam int IW     = $clog2(DEPTH);

  localparam logic [IW:0]   CNT_ONE  = (IW+1)'(1);
  localparam logic [IW:0]   CNT_FULL = (IW+1)'(DEPTH);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [CW-1:0] LAT_ONE  = CW'(1);
  localparam logic [CW-1:0] LAT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] LAT_TO   = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       lat_cnt_q, lat_cnt_d;
  logic [IW:0]         count_q, count_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic [CW-1:0]       latency_q, latency_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [IW-1:0]       mem_waddr;

  logic [IW:0]         last_w;
  logic [CW-1:0]       lat_next;

  // Index of the final buffered word; idx stops here so WAIT can keep reading it.
  assign last_w   = count_q - CNT_ONE;
  // Latency counter saturates instead of wrapping.
  assign lat_next = (lat_cnt_q == LAT_MAX) ? lat_cnt_q : lat_cnt_q + LAT_ONE;

  assign pass    = pass_q;
  assign fail    = fail_q;
  assign latency = latency_q;
  assign count   = count_q;

  // Next-state, datapath updates and Moore outputs of the sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lat_cnt_d = lat_cnt_q;
    count_d   = count_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    latency_d = latency_q;
    mem_we    = 1'b0;
    mem_waddr = count_q[IW-1:0];
    start     = 1'b0;
    d         = '0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // An accepted go wins over a simultaneous load or clear.
        if (go && (count_q != '0)) begin
          state_d = S_START;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end else if (clr) begin
          if (wr_en) begin
            mem_we    = 1'b1;
            mem_waddr = '0;
            count_d   = CNT_ONE;
          end else begin
            count_d   = '0;
          end
        end else if (wr_en && (count_q != CNT_FULL)) begin
          mem_we  = 1'b1;
          count_d = count_q + CNT_ONE;
        end
      end

      S_START: begin
        // done is still stale from the previous run here, so it is not looked at.
        start     = 1'b1;
        busy      = 1'b1;
        idx_d     = '0;
        lat_cnt_d = '0;
        state_d   = S_FEED;
      end

      S_FEED, S_WAIT: begin
        busy      = 1'b1;
        d         = mem_q[idx_q];
        lat_cnt_d = lat_next;
        if (state_q == S_FEED) begin
          if ({1'b0, idx_q} == last_w) begin
            state_d = S_WAIT;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
        // done beats the timeout when both land in the same cycle.
        if (done) begin
          latency_d = lat_cnt_q;
          pass_d    = 1'b1;
          state_d   = S_FINISH;
        end else if (lat_cnt_q == LAT_TO) begin
          latency_d = LAT_TO;
          fail_d    = 1'b1;
          state_d   = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and status registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      lat_cnt_q <= '0;
      count_q   <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      latency_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lat_cnt_q <= lat_cnt_d;
      count_q   <= count_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      latency_q <= latency_d;
    end
  end

  // Word buffer; contents are meaningless after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= wr_data;
    end
  end

endmodule

// File: doc/fsm_stim_driver.md
Name: fsm_stim_driver

Overview:
- Initiator-side sequencer for the 16-bit start/d/done handshake used by the sequence-detector FSM block.
- Holds a small buffer of 16-bit words loaded by the host. On go: issues a one-cycle start, streams the words onto d, waits for done, then reports pass/fail and the measured latency.
- Sits between the host/test logic and the detector. It is the driving end of the interface whose consuming end asserts done.

Parameters:
- DEPTH, 8, number of buffered 16-bit words (power of 2, >=2)
- TIMEOUT, 255, max cycles to wait for done after the first feed cycle
- CW, 8, width of latency counter (2^CW-1 >= TIMEOUT)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  load wr_data into buffer (honoured only in IDLE)
- wr_data  input  16  word to load
- clr  input  1  empty the buffer (honoured only in IDLE)
- go  input  1  launch a run (honoured only in IDLE with count>0)
- start  output  1  one-cycle pulse to the detector
- d  output  16  data word presented to the detector
- done  input  1  completion flag from the detector
- busy  output  1  high from the START state through the cycle before FINISH
- pass  output  1  last run saw done before timeout; sticky until next accepted go
- fail  output  1  last run timed out; sticky until next accepted go
- latency  output  CW  cycles from first FEED to done (or TIMEOUT on fail)
- count  output  $clog2(DEPTH)+1  number of words loaded

Behaviour:
- Reset (async, any state): state=IDLE; start=0, d=0, busy=0, pass=0, fail=0, latency=0, count=0. Buffer contents are don't-care.
- All other updates happen on the rising edge of clk.

States: IDLE, START, FEED, WAIT, FINISH.

IDLE:
- wr_en with count<DEPTH: buf[count]<=wr_data; count++.
- wr_en with count==DEPTH: ignored.
- clr: count<=0. If clr and wr_en occur together: buf[0]<=wr_data, count<=1.
- go with count>0: go to START; pass<=0, fail<=0.
- go with count==0: ignored.
- go has priority over wr_en/clr in the same cycle. The load is dropped, and the run uses the old count.

START (1 cycle):
- start=1, d=0, busy=1. done is ignored (stale from the previous run).
- Set idx<=0, lat_cnt<=0. Next state is FEED.

FEED:
- start=0, d=buf[idx], busy=1.
- idx increments each cycle. The cycle with idx==count-1 moves to WAIT.
- With count==1: exactly one FEED cycle.

WAIT:
- d holds buf[count-1], busy=1.

lat_cnt (FEED and WAIT):
- 0 in the first FEED cycle; increments by 1 every cycle; saturates at 2^CW-1.

done handling (FEED and WAIT):
- done sampled 1: latency<=lat_cnt, pass<=1, next state FINISH. This can abort FEED early; the remaining words are not sent.
- Otherwise, lat_cnt==TIMEOUT: latency<=TIMEOUT, fail<=1, next state FINISH.
- If done==1 and lat_cnt==TIMEOUT in the same cycle, pass wins.

FINISH (1 cycle):
- busy=0, d=0, next state IDLE.
- Buffer and count are retained, so a later go replays the same words.

Invariants:
- start is high only in START.
- pass and fail are never both 1.
- go, wr_en and clr outside IDLE are ignored.

Test Plan:
- Reset mid-FEED (count=4, idx=2) -> outputs asynchronously 0 in the same cycle; state IDLE; count=0; a following go is ignored.
- Load 0x0004, 0x0008, 0x0001; go; bench asserts done in the 3rd cycle after the first FEED -> start high for exactly 1 cycle; d sequence 0x0004, 0x0008, 0x0001, then 0x0001 held; pass=1, latency=3, busy falls after done.
- Load 1 word 0xA5A5; go; done held 0; TIMEOUT=255 -> fail=1, latency=255, pass=0; busy high for 1+256 cycles.
- Load 8 words; wr_en 0x1234 a 9th time -> count stays 8, 0x1234 is never driven. clr+wr_en 0xBEEF together -> count=1, buf[0]=0xBEEF.
- done=1 during the START cycle, then 0 -> ignored, run continues. done=1 in the 1st FEED cycle of a 4-word run -> pass=1, latency=0, only d=buf[0] is sent.
- go while busy, and go with count=0 -> no start pulse, pass/fail unchanged. After a completed run, go again -> identical d sequence is replayed.
